phase_scheduler: RTL

Instruction-cycle sequencer for the FSM processor. It drives the phase code consumed by the datapath and owns the program counter. It handles instruction fetch through a req/ack handshake to program memory, and adds an extra execute phase for long operations. It also supports halt/resume, a sticky fetch timeout error and a retired-instruction counter.

---
 rtl/proc_pkg.sv | 16 +
 rtl/fetch_timer.sv | 20 ++
 rtl/phase_scheduler.sv | 71 +++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: phase/state codes shared with the datapath and default scheduler widths
package proc_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int WAIT_MAX_DEF = 15;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    EXEC1  = 3'b011,
    EXEC2  = 3'b100,
    WB     = 3'b101,
    HALT   = 3'b110,
    ERR    = 3'b111
  } state_e;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts unacknowledged FETCH cycles and flags the last allowed one
module fetch_timer
  import proc_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(WAIT_MAX + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + W'(1);
  end
  assign expire = enable && cnt_q == W'(WAIT_MAX - 1);
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: instruction-cycle sequencer owning the phase code, pc and retired count
module phase_scheduler
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              mem_ack,
  input  logic              long_op,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [2:0]        phase,
  output logic              mem_req,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  retired
);
  state_e state_q, state_d;
  logic long_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0] ret_q;
  logic expire;
  fetch_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(state_q != FETCH),
    .enable(state_q == FETCH && !mem_ack),
    .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: state_d = start ? FETCH : state_q;
      FETCH: state_d = mem_ack ? DECODE : (expire ? ERR : FETCH);
      DECODE: state_d = EXEC1;
      EXEC1: state_d = long_q ? EXEC2 : WB;
      EXEC2: state_d = WB;
      WB: state_d = halt_req ? HALT : FETCH;
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      long_q <= 1'b0;
      pc_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) long_q <= long_op;
      if (state_q == WB) begin
        pc_q <= branch_taken ? branch_target : pc_q + ADDR_W'(1);
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end
  assign phase = state_q;
  assign mem_req = state_q == FETCH;
  assign busy = !(state_q inside {IDLE, HALT, ERR});
  assign err = state_q == ERR;
  assign pc = pc_q;
  assign fetch_addr = pc_q;
  assign retired = ret_q;
endmodule
